// File: rtl/data_uart_tx.sv
// data_uart_tx: prints each new 16-bit data_in value on a UART line as four uppercase ASCII
// hex digits followed by CR LF. Characters are 8N1, LSB first, each bit held
// Div = ClkFreq / Baud cycles.
// Optional feature: define DATA_UART_PARITY_EN to send 8E1 characters, with an even-parity
// bit between data bit 7 and the stop bit.
module data_uart_tx #(
  parameter int unsigned ClkFreq = 50_000_000,
  parameter int unsigned Baud    = 115200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] data_in_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned Div  = ClkFreq / Baud;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef DATA_UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     last_sent_q, last_sent_d;
  logic [15:0]     snap_q, snap_d;
  logic [2:0]      char_idx_q, char_idx_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_end;
  logic [7:0]      cur_char;

  // Character idx of the frame for value v: four hex digits, then CR, then LF.
  function automatic logic [7:0] char_of(input logic [15:0] v, input logic [2:0] idx);
    logic [3:0] nib;
    logic [7:0] c;
    nib = 4'h0;
    case (idx)
      3'd0:    nib = v[15:12];
      3'd1:    nib = v[11:8];
      3'd2:    nib = v[7:4];
      3'd3:    nib = v[3:0];
      default: nib = 4'h0;
    endcase
    if (idx < 3'd4) begin
      c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (idx == 3'd4) begin
      c = 8'h0D;
    end else begin
      c = 8'h0A;
    end
    return c;
  endfunction

  assign bit_end = (baud_q == CntMax);

  // Next-state logic; tx and busy are derived from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    last_sent_d = last_sent_q;
    snap_d      = snap_q;
    char_idx_d  = char_idx_q;
    bit_idx_d   = bit_idx_q;
    baud_d      = '0;
    tx_d        = 1'b1;
    busy_d      = 1'b0;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (data_in_i != last_sent_q) begin
          snap_d      = data_in_i;
          last_sent_d = data_in_i;
          char_idx_d  = 3'd0;
          bit_idx_d   = 3'd0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef DATA_UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef DATA_UART_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (char_idx_q == 3'd5) begin
            state_d = StIdle;
          end else begin
            char_idx_d = char_idx_q + 3'd1;
            state_d    = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    cur_char = char_of(snap_d, char_idx_d);
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = cur_char[bit_idx_d];
`ifdef DATA_UART_PARITY_EN
      StParity: tx_d = ^cur_char;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_sent_q <= 16'h0000;
      snap_q      <= 16'h0000;
      char_idx_q  <= 3'd0;
      bit_idx_q   <= 3'd0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_sent_q <= last_sent_d;
      snap_q      <= snap_d;
      char_idx_q  <= char_idx_d;
      bit_idx_q   <= bit_idx_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
